// File: rtl/alu_divider_seq_if.sv
// ---------------------------------------------------------------------------
// alu_divider_seq_if
// Handshake/data bundle for the sequential DIV unit that sits beside the ALU.
//   start        request, sampled by the divider only while busy=0
//   dividend     numerator   (DIVIDEND_W bits)
//   divisor      denominator (DIVISOR_W bits)
//   signed_op    two's complement request (only when ALU_DIV_SIGNED_EN is defined)
//   busy         division in progress
//   done         one-cycle completion pulse
//   quotient     registered quotient  (DIVIDEND_W bits)
//   remainder    registered remainder (DIVISOR_W bits)
//   div_by_zero  registered flag for the last completed operation
// master = requester side, slave = divider side.
// ---------------------------------------------------------------------------
interface alu_divider_seq_if #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
);
  logic                  start;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
`ifdef ALU_DIV_SIGNED_EN
  logic                  signed_op;
`endif
  logic                  busy;
  logic                  done;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;

  modport master (
`ifdef ALU_DIV_SIGNED_EN
    output signed_op,
`endif
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
`ifdef ALU_DIV_SIGNED_EN
    input  signed_op,
`endif
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/alu_divider_seq.sv
// ---------------------------------------------------------------------------
// alu_divider_seq
// Sequential restoring divider, one quotient bit per clock. Inverse of the
// ALU 4x4 multiply: 8-bit dividend / 4-bit divisor -> 8-bit quotient and
// 4-bit remainder, with a start/busy/done handshake.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    alu_divider_seq_if.slave (start, operands, busy, done, results)
// Optional feature: define ALU_DIV_SIGNED_EN to add bus.signed_op and
// two's complement division (truncation toward zero). Default build is
// unsigned only.
// ---------------------------------------------------------------------------
module alu_divider_seq #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_divider_seq_if.slave  bus
);

  localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIVIDEND_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_ZERO = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_dbz;
  logic [DIVIDEND_W-1:0] r_dq;        // unconsumed dividend bits above, quotient bits below
  logic [DIVIDEND_W-1:0] r_quotient;
  logic [DIVISOR_W-1:0]  r_divisor;
  logic [DIVISOR_W-1:0]  r_p;         // partial remainder, always < divisor between steps
  logic [DIVISOR_W-1:0]  r_remainder;
  logic [CNT_W-1:0]      r_cnt;

  logic                  w_last;
  logic                  w_qbit;
  logic [DIVISOR_W:0]    w_p_shift;
  logic [DIVISOR_W:0]    w_p_sub;
  logic [DIVISOR_W-1:0]  w_p_next;
  logic [DIVIDEND_W-1:0] w_q_raw;
  logic [DIVIDEND_W-1:0] w_q_final;
  logic [DIVISOR_W-1:0]  w_r_final;
  logic [DIVIDEND_W-1:0] w_dd_mag;
  logic [DIVISOR_W-1:0]  w_dv_mag;
`ifdef ALU_DIV_SIGNED_EN
  logic                  r_neg_q;
  logic                  r_neg_r;
  logic                  w_neg_q;
  logic                  w_neg_r;
`endif

  // Restoring step, operand magnitudes and final result formatting
  always_comb begin
    w_last    = (r_cnt == LAST_CNT);
    w_p_shift = {r_p, r_dq[DIVIDEND_W-1]};
    w_p_sub   = w_p_shift - {1'b0, r_divisor};
    // P' < 2*divisor, so the subtraction borrows exactly when P' < divisor
    w_qbit    = ~w_p_sub[DIVISOR_W];
    w_p_next  = w_qbit ? w_p_sub[DIVISOR_W-1:0] : w_p_shift[DIVISOR_W-1:0];
    w_q_raw   = {r_dq[DIVIDEND_W-2:0], w_qbit};
`ifdef ALU_DIV_SIGNED_EN
    w_dd_mag  = (bus.signed_op && bus.dividend[DIVIDEND_W-1]) ?
                (DIVIDEND_W'(0) - bus.dividend) : bus.dividend;
    w_dv_mag  = (bus.signed_op && bus.divisor[DIVISOR_W-1]) ?
                (DIVISOR_W'(0) - bus.divisor) : bus.divisor;
    w_neg_q   = bus.signed_op && (bus.dividend[DIVIDEND_W-1] ^ bus.divisor[DIVISOR_W-1]);
    w_neg_r   = bus.signed_op && bus.dividend[DIVIDEND_W-1];
    // -128/-1 needs no special case: 128/1 = 8'h80 with equal signs
    w_q_final = r_neg_q ? (DIVIDEND_W'(0) - w_q_raw) : w_q_raw;
    w_r_final = r_neg_r ? (DIVISOR_W'(0) - w_p_next) : w_p_next;
`else
    w_dd_mag  = bus.dividend;
    w_dv_mag  = bus.divisor;
    w_q_final = w_q_raw;
    w_r_final = w_p_next;
`endif
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = (bus.divisor == {DIVISOR_W{1'b0}}) ? S_ZERO : S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_ZERO:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand capture, iteration datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_dbz       <= 1'b0;
      r_dq        <= {DIVIDEND_W{1'b0}};
      r_quotient  <= {DIVIDEND_W{1'b0}};
      r_divisor   <= {DIVISOR_W{1'b0}};
      r_p         <= {DIVISOR_W{1'b0}};
      r_remainder <= {DIVISOR_W{1'b0}};
      r_cnt       <= {CNT_W{1'b0}};
`ifdef ALU_DIV_SIGNED_EN
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_dq      <= w_dd_mag;
            r_divisor <= w_dv_mag;
            r_p       <= {DIVISOR_W{1'b0}};
            r_cnt     <= {CNT_W{1'b0}};
            r_busy    <= 1'b1;
`ifdef ALU_DIV_SIGNED_EN
            r_neg_q   <= w_neg_q;
            r_neg_r   <= w_neg_r;
`endif
          end
        end
        S_RUN: begin
          r_p   <= w_p_next;
          r_dq  <= w_q_raw;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_quotient  <= w_q_final;
            r_remainder <= w_r_final;
            r_dbz       <= 1'b0;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        S_ZERO: begin
          r_quotient  <= {DIVIDEND_W{1'b1}};
          r_remainder <= {DIVISOR_W{1'b0}};
          r_dbz       <= 1'b1;
          r_done      <= 1'b1;
          r_busy      <= 1'b0;
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_alu_divider_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_divider_seq
// Directed bench for alu_divider_seq: reset state, latency, back-to-back
// starts, divide-by-zero, ignored start while busy, reset mid-operation and
// (with ALU_DIV_SIGNED_EN) signed results. Inputs driven and outputs sampled
// on the falling edge; the DUT acts on the rising edge.
// ---------------------------------------------------------------------------
module tb_alu_divider_seq;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic seen_done;

  alu_divider_seq_if #(.DIVIDEND_W(8), .DIVISOR_W(4)) dif ();

  alu_divider_seq #(.DIVIDEND_W(8), .DIVISOR_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Request one division; returns at the falling edge after the accepting edge
  task automatic issue(input logic [7:0] dd, input logic [3:0] dv);
    dif.start    = 1'b1;
    dif.dividend = dd;
    dif.divisor  = dv;
    @(negedge clk);
    dif.start    = 1'b0;
  endtask

  // Wait for done (bounded), then check latency and results
  task automatic finish_div(input int lat, input logic [7:0] q, input logic [3:0] r,
                            input logic z, input string tag);
    int cyc;
    cyc = 0;
    while (dif.done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc != lat) begin
      errors++;
      $error("FAIL %s latency: observed %0d expected %0d", tag, cyc, lat);
    end
    checks++;
    if (dif.quotient !== q) begin
      errors++;
      $error("FAIL %s quotient: observed %0h expected %0h", tag, dif.quotient, q);
    end
    checks++;
    if (dif.remainder !== r) begin
      errors++;
      $error("FAIL %s remainder: observed %0h expected %0h", tag, dif.remainder, r);
    end
    checks++;
    if (dif.div_by_zero !== z) begin
      errors++;
      $error("FAIL %s div_by_zero: observed %0h expected %0h", tag, dif.div_by_zero, z);
    end
    checks++;
    if (dif.busy !== 1'b0) begin
      errors++;
      $error("FAIL %s busy at done: observed %0h expected 0", tag, dif.busy);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    seen_done    = 1'b0;
    rst_n        = 1'b0;
    dif.start    = 1'b0;
    dif.dividend = 8'd0;
    dif.divisor  = 4'd0;
`ifdef ALU_DIV_SIGNED_EN
    dif.signed_op = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (dif.busy !== 1'b0) begin
      errors++;
      $error("FAIL reset busy: observed %0h expected 0", dif.busy);
    end
    checks++;
    if (dif.done !== 1'b0) begin
      errors++;
      $error("FAIL reset done: observed %0h expected 0", dif.done);
    end
    checks++;
    if (dif.quotient !== 8'd0) begin
      errors++;
      $error("FAIL reset quotient: observed %0h expected 0", dif.quotient);
    end
    checks++;
    if (dif.remainder !== 4'd0) begin
      errors++;
      $error("FAIL reset remainder: observed %0h expected 0", dif.remainder);
    end
    checks++;
    if (dif.div_by_zero !== 1'b0) begin
      errors++;
      $error("FAIL reset div_by_zero: observed %0h expected 0", dif.div_by_zero);
    end

    // 100/7: busy through 7 edges after acceptance, done on the 8th
    issue(8'd100, 4'd7);
    checks++;
    if (dif.busy !== 1'b1) begin
      errors++;
      $error("FAIL 100/7 busy after accept: observed %0h expected 1", dif.busy);
    end
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (dif.busy !== 1'b1) begin
        errors++;
        $error("FAIL 100/7 busy in run: observed %0h expected 1", dif.busy);
      end
      checks++;
      if (dif.done !== 1'b0) begin
        errors++;
        $error("FAIL 100/7 no early done: observed %0h expected 0", dif.done);
      end
    end
    finish_div(1, 8'd14, 4'd2, 1'b0, "100/7");

    // Back-to-back boundaries, each started in the previous done cycle
    issue(8'd255, 4'd1);
    finish_div(8, 8'd255, 4'd0, 1'b0, "255/1");
    issue(8'd225, 4'd15);
    checks++;
    if (dif.quotient !== 8'd255) begin
      errors++;
      $error("FAIL quotient held while running: observed %0h expected ff", dif.quotient);
    end
    finish_div(8, 8'd15, 4'd0, 1'b0, "225/15");
    issue(8'd3, 4'd15);
    finish_div(8, 8'd0, 4'd3, 1'b0, "3/15");

    // Divide by zero, then a normal division clears the flag
    issue(8'd42, 4'd0);
    finish_div(1, 8'hFF, 4'd0, 1'b1, "42/0");
    issue(8'd9, 4'd2);
    checks++;
    if (dif.div_by_zero !== 1'b1) begin
      errors++;
      $error("FAIL div_by_zero held while running: observed %0h expected 1", dif.div_by_zero);
    end
    finish_div(8, 8'd4, 4'd1, 1'b0, "9/2");

    // Start pulse while busy must be ignored
    issue(8'd100, 4'd7);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (dif.busy !== 1'b1) begin
        errors++;
        $error("FAIL busy during ignored start: observed %0h expected 1", dif.busy);
      end
      dif.start    = (i == 2);
      dif.dividend = 8'd50;
      dif.divisor  = 4'd5;
    end
    finish_div(1, 8'd14, 4'd2, 1'b0, "100/7 ignore start");
    @(negedge clk);
    checks++;
    if (dif.busy !== 1'b0) begin
      errors++;
      $error("FAIL no stray operation: observed %0h expected 0", dif.busy);
    end

    // Asynchronous reset in the middle of a run
    issue(8'd200, 4'd3);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (dif.busy !== 1'b0) begin
      errors++;
      $error("FAIL mid-run reset busy: observed %0h expected 0", dif.busy);
    end
    checks++;
    if (dif.done !== 1'b0) begin
      errors++;
      $error("FAIL mid-run reset done: observed %0h expected 0", dif.done);
    end
    checks++;
    if (dif.quotient !== 8'd0) begin
      errors++;
      $error("FAIL mid-run reset quotient: observed %0h expected 0", dif.quotient);
    end
    checks++;
    if (dif.remainder !== 4'd0) begin
      errors++;
      $error("FAIL mid-run reset remainder: observed %0h expected 0", dif.remainder);
    end
    checks++;
    if (dif.div_by_zero !== 1'b0) begin
      errors++;
      $error("FAIL mid-run reset div_by_zero: observed %0h expected 0", dif.div_by_zero);
    end
    #3;
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (dif.done === 1'b1) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin
      errors++;
      $error("FAIL no done after reset: observed %0h expected 0", seen_done);
    end
    checks++;
    if (dif.busy !== 1'b0) begin
      errors++;
      $error("FAIL idle after reset: observed %0h expected 0", dif.busy);
    end
    issue(8'd200, 4'd3);
    finish_div(8, 8'd66, 4'd2, 1'b0, "200/3");

`ifdef ALU_DIV_SIGNED_EN
    dif.signed_op = 1'b1;
    issue(8'h9C, 4'd7);
    finish_div(8, 8'hF2, 4'hE, 1'b0, "-100/7");
    issue(8'd100, 4'h9);
    finish_div(8, 8'hF2, 4'd2, 1'b0, "100/-7");
    issue(8'h80, 4'hF);
    finish_div(8, 8'h80, 4'd0, 1'b0, "-128/-1");
    dif.signed_op = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global guard against a stuck run
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_divider_seq.md
Name: alu_divider_seq

Overview:
- Sequential restoring divider. It is the inverse of the ALU's 4x4 multiply path: it takes an 8-bit dividend (for example an ALU MUL result) and a 4-bit divisor.
- Produces an 8-bit quotient and a 4-bit remainder, one quotient bit per clock.
- Sits beside the combinational ALU as a multi-cycle DIV unit with a start/done handshake.

Parameters:
- DIVIDEND_W, 8, dividend and quotient width; also the iteration count.
- DIVISOR_W, 4, divisor and remainder width.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- dividend  input  DIVIDEND_W  numerator; captured on the accepting edge.
- divisor  input  DIVISOR_W  denominator; captured on the accepting edge.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse; results valid from this cycle.
- quotient  output  DIVIDEND_W  registered quotient; held until next completion.
- remainder  output  DIVISOR_W  registered remainder; held until next completion.
- div_by_zero  output  1  registered flag for the last completed operation.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; iteration counter=0; operand registers=0.
- States:
  - IDLE: start=1 accepts the operands.
    - Divisor != 0 -> RUN; busy=1 on the same edge; counter=0.
    - Divisor = 0 -> ZERO.
  - RUN: one restoring step per edge.
    - Partial remainder P is DIVISOR_W+1 bits.
    - P' = {P[DIVISOR_W-1:0], next dividend MSB}; if P' >= divisor then P = P' - divisor and shift in q=1, else P = P' and q=0.
    - Dividend bits are consumed MSB first.
    - After DIVIDEND_W steps, on that same edge: load quotient/remainder, done=1, busy=0, div_by_zero=0, state -> IDLE.
  - ZERO: one cycle. Next edge: quotient = all ones, remainder = 0, div_by_zero=1, done=1, busy=0 -> IDLE.
- Latency:
  - Normal: done high exactly DIVIDEND_W cycles after the accepting edge (8 at defaults).
  - Divide-by-zero: done high 1 cycle after the accepting edge.
- done is high for exactly one cycle; it deasserts on the next edge unless a new completion occurs.
- start while busy=1 is ignored; operand inputs are don't-care while busy.
- start sampled in the done cycle (busy=0) is accepted back-to-back; outputs keep the previous result until the new completion.
- quotient, remainder and div_by_zero change only on a completing edge; outputs are stable between completions.
- Arithmetic is unsigned.
  - Quotient max 2^DIVIDEND_W-1 (divisor=1).
  - Remainder is always < divisor, so it fits DIVISOR_W bits.
  - No overflow is possible in unsigned mode.
- Reset asserted mid-RUN: the operation is abandoned immediately, all outputs return to reset values, and no done pulse is produced.

Optional Feature:
- Macro: ALU_DIV_SIGNED_EN.
- Defined:
  - Adds input port signed_op (1 bit, captured with the operands).
  - When signed_op=1, dividend and divisor are two's complement.
  - Magnitudes are formed at capture and the unsigned core runs unchanged; latency is unchanged.
  - At completion: quotient negated if the operand signs differ; remainder takes the dividend's sign (truncation toward zero).
  - Most-negative / -1 case (e.g. -128 / -1): quotient = 8'h80, remainder = 0, div_by_zero = 0.
  - Divide-by-zero behaves as in unsigned mode regardless of sign.
  - signed_op=0 is identical to the undefined build.
- Undefined: no signed_op port; unsigned only.

Test Plan:
- Reset then start with dividend=100, divisor=7 -> busy=1 for 8 cycles; done pulse on cycle 8; quotient=14, remainder=2, div_by_zero=0.
- Boundary values, back-to-back with start asserted in each done cycle:
  - 255/1 -> q=255, r=0.
  - 225/15 -> q=15, r=0.
  - 3/15 -> q=0, r=3.
  - Each completes 8 cycles after acceptance.
- dividend=42, divisor=0 -> done 1 cycle after accept; q=8'hFF, r=0, div_by_zero=1.
- Next division 9/2 -> div_by_zero=0, q=4, r=1.
- Start 100/7; at cycle 3 assert start with 50/5 -> second request ignored; result is q=14, r=2; busy stays high through cycle 7.
- Start 200/3; pull rst_n low at cycle 4 for half a cycle -> busy, done and outputs are 0 immediately, and no done pulse follows.
- Then 200/3 to completion -> q=66, r=2.
- With ALU_DIV_SIGNED_EN and signed_op=1:
  - -100/7 -> q=8'hF2 (-14), r=4'hE (-2).
  - 100/-7 -> q=8'hF2, r=2.
  - -128/-1 -> q=8'h80, r=0.
